// File: rtl/fsm_receptor.sv
// fsm_receptor: receiving end of the processor send/ack 4-phase handshake.
// Each accepted word is written into a small circular FIFO. A local consumer
// drains the FIFO through a registered read port. While the FIFO is full, a
// write request is held off in STALL until space frees up.
module fsm_receptor #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    send,
  input  logic [DW-1:0] dado,
  output logic [1:0]    ack,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          proto_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [DW-1:0] rd_data_reg;
  logic          rd_valid_reg;
  logic          err_reg, err_next;

  logic [DW-1:0] mem [DEPTH];

  logic req, illegal, push, pop, full_w, empty_w;

  // Illegal codes (2'b1x) are flagged and otherwise behave like idle.
  assign req     = (send == 2'b01);
  assign illegal = send[1];

  // Fill flags come from the registered count, so push acceptance always
  // sees the level before the edge (a same-cycle pop cannot make room).
  assign full_w  = (count_reg == DEPTH_CNT);
  assign empty_w = (count_reg == '0);
  assign pop     = rd_en && !empty_w;

  // Next-state, write-enable and error decode for the handshake FSM.
  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    err_next   = err_reg | illegal;
    case (state_reg)
      IDLE: begin
        if (req) begin
          if (!full_w) begin
            push       = 1'b1;
            state_next = ACK;
          end else begin
            state_next = STALL;
          end
        end
      end
      STALL: begin
        if (req) begin
          if (!full_w) begin
            push       = 1'b1;
            state_next = ACK;
          end
        end else begin
          // Request withdrawn before it was ever acknowledged.
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      ACK: begin
        // One word per handshake: wait for the processor to drop send.
        if (!req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control registers: FSM state, pointers, fill level, read port, error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      err_reg      <= err_next;
      rd_valid_reg <= pop;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        rd_data_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage array is left unreset so it maps onto RAM; reset discards
  // contents logically by clearing the pointers and count. The push is
  // gated by rst so a write cannot land during reset.
  always_ff @(posedge clk) begin
    if (push && rst) mem[wr_ptr_reg] <= dado;
  end

  assign ack       = (state_reg == ACK) ? 2'b01 : 2'b00;
  assign rd_data   = rd_data_reg;
  assign rd_valid  = rd_valid_reg;
  assign empty     = empty_w;
  assign full      = full_w;
  assign count     = count_reg;
  assign proto_err = err_reg;

endmodule

// File: tb/tb_fsm_receptor.sv
// tb_fsm_receptor: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of the receptor.
module tb_fsm_receptor;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  send;
  logic [15:0] dado;
  logic [1:0]  ack;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        proto_err;

  int n_cmp = 0;
  int n_mis = 0;
  int n_txn = 0;

  // Reference model state
  logic [15:0] m_q[$];
  bit          m_in_handshake;  // word taken, waiting for send to drop
  bit          m_waiting;       // request seen while full, not yet taken
  bit          m_err;
  bit          m_rd_valid;
  logic [15:0] m_rd_data;

  fsm_receptor #(.DW(16), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .send(send), .dado(dado), .ack(ack),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full), .count(count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one rising edge worth of the handshake rules to the model.
  task automatic model_edge();
    int  sz;
    bit  req, took;
    if (!rst) begin
      m_q.delete();
      m_in_handshake = 0;
      m_waiting      = 0;
      m_err          = 0;
      m_rd_valid     = 0;
      m_rd_data      = '0;
      return;
    end
    sz   = m_q.size();
    req  = (send == 2'b01);
    took = 0;
    if (send[1]) m_err = 1;
    if (m_in_handshake) begin
      if (!req) m_in_handshake = 0;
    end else if (req) begin
      if (sz < 4) begin
        took           = 1;
        m_in_handshake = 1;
        m_waiting      = 0;
      end else begin
        m_waiting = 1;
      end
    end else begin
      if (m_waiting) m_err = 1;
      m_waiting = 0;
    end
    m_rd_valid = rd_en && (sz > 0);
    if (m_rd_valid) m_rd_data = m_q.pop_front();
    if (took) m_q.push_back(dado);
  endtask

  task automatic check_all();
    check("ack",       32'(ack),       m_in_handshake ? 32'd1 : 32'd0);
    check("count",     32'(count),     32'(m_q.size()));
    check("empty",     32'(empty),     32'(m_q.size() == 0));
    check("full",      32'(full),      32'(m_q.size() == 4));
    check("rd_valid",  32'(rd_valid),  32'(m_rd_valid));
    check("rd_data",   32'(rd_data),   32'(m_rd_data));
    check("proto_err", 32'(proto_err), 32'(m_err));
  endtask

  // One transaction = one clock: drive at negedge, model the edge, check.
  task automatic cyc(input logic [1:0] s, input logic [15:0] d, input logic re, input logic r);
    send  = s;
    dado  = d;
    rd_en = re;
    rst   = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    n_txn++;
    $display("txn %0d rst=%0b send=%0b dado=%h rd_en=%0b -> ack=%0b cnt=%0d rv=%0b rd=%h err=%0b",
             n_txn, r, s, d, re, ack, count, rd_valid, rd_data, proto_err);
    check_all();
  endtask

  task automatic handshake(input logic [15:0] d);
    cyc(2'b01, d, 1'b0, 1'b1);
    cyc(2'b00, 16'h0, 1'b0, 1'b1);
  endtask

  initial begin
    send = 2'b00; dado = '0; rd_en = 1'b0; rst = 1'b0;

    // 1: reset held with a pending request
    cyc(2'b01, 16'h1234, 1'b0, 1'b0);
    cyc(2'b01, 16'h1234, 1'b0, 1'b0);
    check("rst_ack",   32'(ack),       32'd0);
    check("rst_empty", 32'(empty),     32'd1);
    check("rst_count", 32'(count),     32'd0);
    check("rst_err",   32'(proto_err), 32'd0);
    cyc(2'b00, 16'h0, 1'b0, 1'b1);

    // 2: single word round trip
    cyc(2'b01, 16'hBEEF, 1'b0, 1'b1);
    check("single_ack1", 32'(ack), 32'd1);
    cyc(2'b00, 16'h0, 1'b0, 1'b1);
    check("single_ack0", 32'(ack), 32'd0);
    cyc(2'b00, 16'h0, 1'b1, 1'b1);
    check("single_rd",    32'(rd_data),  32'hBEEF);
    check("single_rv",    32'(rd_valid), 32'd1);
    check("single_empty", 32'(empty),    32'd1);

    // 3: fill, stall, deferred push across a same-cycle pop, wrap-around reads
    for (int i = 1; i <= 4; i++) handshake(16'(i));
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd4);
    cyc(2'b01, 16'h0005, 1'b0, 1'b1);
    check("stall_ack", 32'(ack), 32'd0);
    cyc(2'b01, 16'h0005, 1'b1, 1'b1);
    check("defer_ack", 32'(ack),     32'd0);
    check("pop1",      32'(rd_data), 32'h0001);
    cyc(2'b01, 16'h0005, 1'b0, 1'b1);
    check("stall_take_ack", 32'(ack), 32'd1);
    cyc(2'b00, 16'h0, 1'b0, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      cyc(2'b00, 16'h0, 1'b1, 1'b1);
      check("wrap_rd", 32'(rd_data), 32'(i));
    end

    // 4: simultaneous push and pop at count=2
    handshake(16'h1111);
    handshake(16'h2222);
    cyc(2'b01, 16'hA5A5, 1'b1, 1'b1);
    check("sim_count", 32'(count),   32'd2);
    check("sim_rd",    32'(rd_data), 32'h1111);
    cyc(2'b00, 16'h0, 1'b1, 1'b1);
    cyc(2'b00, 16'h0, 1'b1, 1'b1);
    check("sim_last", 32'(rd_data), 32'hA5A5);

    // 5: protocol errors
    cyc(2'b11, 16'hDEAD, 1'b0, 1'b1);
    check("ill_err",   32'(proto_err), 32'd1);
    check("ill_ack",   32'(ack),       32'd0);
    check("ill_count", 32'(count),     32'd0);
    cyc(2'b00, 16'h0, 1'b0, 1'b0);
    cyc(2'b00, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) handshake(16'h4000 + 16'(i));
    cyc(2'b01, 16'h4444, 1'b0, 1'b1);
    cyc(2'b00, 16'h0, 1'b0, 1'b1);
    check("drop_err", 32'(proto_err), 32'd1);

    // 6: reset during ACK with count=3
    cyc(2'b00, 16'h0, 1'b0, 1'b0);
    handshake(16'h6001);
    handshake(16'h6002);
    cyc(2'b01, 16'h6003, 1'b0, 1'b1);
    check("mid_ack", 32'(ack), 32'd1);
    cyc(2'b01, 16'h6003, 1'b0, 1'b0);
    check("mid_rst_ack",   32'(ack),   32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    cyc(2'b01, 16'h7777, 1'b0, 1'b1);
    check("post_ack", 32'(ack), 32'd1);
    cyc(2'b00, 16'h0, 1'b1, 1'b1);
    check("post_rd", 32'(rd_data), 32'h7777);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      int unsigned p;
      logic [1:0]  s;
      logic        r, re;
      p  = $urandom_range(99);
      if (p < 4)       s = {1'b1, 1'($urandom_range(1))};
      else if (p < 55) s = 2'b01;
      else             s = 2'b00;
      r  = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
      re = ($urandom_range(99) < 35) ? 1'b1 : 1'b0;
      cyc(s, 16'($urandom()), re, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
